// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage and the opcode decoder:
// field positions, widths, the bubble word and the fetch FSM state type.
package instr_fetch_stage_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 16;

  localparam int unsigned OPC_MSB   = 31;
  localparam int unsigned OPC_LSB   = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned IMM_MSB   = 15;
  localparam int unsigned IMM_LSB   = 0;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;

  // Opcode 000000 with funct 000000 decodes to no operation.
  localparam logic [XLEN-1:0] NOP_WORD    = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HOLD,
    ST_REDIRECT
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, fetch counter
// and a four-state control FSM (boot, run, hold, redirect after a branch).
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [XLEN-1:0]    branch_target,
  input  logic [XLEN-1:0]    ibus,
  output logic [XLEN-1:0]    iaddrbus,
  output logic [XLEN-1:0]    ifid_instr,
  output logic [XLEN-1:0]    ifid_pc4,
  output logic               ifid_valid,
  output logic [OPC_W-1:0]   ibus_opcode,
  output logic [FUNCT_W-1:0] funct,
  output logic [REG_W-1:0]   rs,
  output logic [REG_W-1:0]   rt,
  output logic [REG_W-1:0]   rd,
  output logic [IMM_W-1:0]   imm16,
  output logic [CNT_W-1:0]   fetch_count
);

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0]  ifid_pc4_q, ifid_pc4_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
  logic [XLEN-1:0]  pc_plus4;

  // Wraps modulo 2^32 naturally; the PC never saturates.
  assign pc_plus4 = pc_q + INSTR_BYTES;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case/if tree can leave it unassigned and infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc4_d    = ifid_pc4_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;

    if (branch_taken) begin
      // Redirect wins over stall: squash whatever is on ibus this cycle.
      pc_d         = word_align(branch_target);
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      state_d      = ST_REDIRECT;
    end else begin
      unique case (state_q)
        ST_BOOT: begin
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          state_d      = ST_RUN;
        end
        ST_RUN, ST_HOLD, ST_REDIRECT: begin
          if (stall) begin
            state_d = ST_HOLD;
          end else begin
            pc_d          = pc_plus4;
            ifid_instr_d  = ibus;
            ifid_pc4_d    = pc_plus4;
            ifid_valid_d  = 1'b1;
            fetch_count_d = fetch_count_q + CNT_W'(1);
            state_d       = ST_RUN;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      ifid_instr_q  <= NOP_INSTR;
      ifid_pc4_q    <= '0;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc4_q    <= ifid_pc4_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // The address bus comes straight from the PC flop: no input reaches it
  // combinationally.
  assign iaddrbus    = pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc4    = ifid_pc4_q;
  assign ifid_valid  = ifid_valid_q;
  assign fetch_count = fetch_count_q;

  assign ibus_opcode = ifid_instr_q[OPC_MSB:OPC_LSB];
  assign rs          = ifid_instr_q[RS_MSB:RS_LSB];
  assign rt          = ifid_instr_q[RT_MSB:RT_LSB];
  assign rd          = ifid_instr_q[RD_MSB:RD_LSB];
  assign imm16       = ifid_instr_q[IMM_MSB:IMM_LSB];
  assign funct       = ifid_instr_q[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: boot sequence, stall, branch/stall
// priority, PC wrap, asynchronous reset and decode slices.
module tb_instr_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] ibus;
  logic        use_ovr;
  logic [31:0] ovr_word;

  logic [31:0] iaddrbus, ifid_instr, ifid_pc4;
  logic        ifid_valid;
  logic [5:0]  ibus_opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16, fetch_count;

  logic [31:0] w_iaddrbus, w_ifid_instr, w_ifid_pc4;
  logic        w_ifid_valid;
  logic [5:0]  w_ibus_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [15:0] w_imm16, w_fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .ibus(ibus), .iaddrbus(iaddrbus),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
    .ibus_opcode(ibus_opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
    .imm16(imm16), .fetch_count(fetch_count)
  );

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .ibus(ibus), .iaddrbus(w_iaddrbus),
    .ifid_instr(w_ifid_instr), .ifid_pc4(w_ifid_pc4), .ifid_valid(w_ifid_valid),
    .ibus_opcode(w_ibus_opcode), .funct(w_funct), .rs(w_rs), .rt(w_rt), .rd(w_rd),
    .imm16(w_imm16), .fetch_count(w_fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: the word at an address is a fixed tag OR address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  always_comb ibus = use_ovr ? ovr_word : word_at(iaddrbus);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] pc,
                             input logic [31:0] instr, input logic [15:0] cnt);
    check({tag, "_pc"}, iaddrbus, pc);
    check({tag, "_instr"}, ifid_instr, instr);
    check({tag, "_valid"}, {31'd0, ifid_valid}, 32'd1);
    check({tag, "_cnt"}, {16'd0, fetch_count}, {16'd0, cnt});
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    use_ovr = 1'b0; ovr_word = '0;
    #12;
    check("rst_pc", iaddrbus, 32'h0);
    check("rst_instr", ifid_instr, 32'h0);
    check("rst_pc4", ifid_pc4, 32'h0);
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_cnt", {16'd0, fetch_count}, 32'd0);
    check("rst_wrap_pc", w_iaddrbus, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    // Boot edge: PC holds, bubble loaded.
    step();
    check("boot_pc", iaddrbus, 32'h0);
    check("boot_valid", {31'd0, ifid_valid}, 32'd0);
    check("boot_cnt", {16'd0, fetch_count}, 32'd0);

    // Sequential run.
    step();
    check_fetch("run1", 32'h4, word_at(32'h0), 16'd1);
    check("run1_pc4", ifid_pc4, 32'h4);
    check("wrap_pc", w_iaddrbus, 32'h0);
    check("wrap_pc4", w_ifid_pc4, 32'h0);
    step();
    check_fetch("run2", 32'h8, word_at(32'h4), 16'd2);
    step();
    check_fetch("run3", 32'hC, word_at(32'h8), 16'd3);
    step();
    check_fetch("run4", 32'h10, word_at(32'hC), 16'd4);

    // Three stalled cycles at PC=0x10.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_fetch("stall", 32'h10, word_at(32'hC), 16'd4);
    end
    stall = 1'b0;
    step();
    check_fetch("unstall", 32'h14, word_at(32'h10), 16'd5);
    check("unstall_pc4", ifid_pc4, 32'h14);

    // Branch and stall together: branch wins.
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0100;
    step();
    check("brst_pc", iaddrbus, 32'h100);
    check("brst_valid", {31'd0, ifid_valid}, 32'd0);
    check("brst_opc", {26'd0, ibus_opcode}, 32'd0);
    check("brst_funct", {26'd0, funct}, 32'd0);
    check("brst_cnt", {16'd0, fetch_count}, 32'd5);
    check("brst_pc4", ifid_pc4, 32'h14);
    branch_taken = 1'b0;
    step();
    check("redir_hold_pc", iaddrbus, 32'h100);
    check("redir_hold_valid", {31'd0, ifid_valid}, 32'd0);
    stall = 1'b0;
    step();
    check_fetch("hold_rel", 32'h104, word_at(32'h100), 16'd6);
    check("hold_rel_pc4", ifid_pc4, 32'h104);

    // Unaligned target is forced to a word boundary.
    branch_taken = 1'b1; branch_target = 32'h0000_0203;
    step();
    check("align_pc", iaddrbus, 32'h200);
    check("align_valid", {31'd0, ifid_valid}, 32'd0);
    branch_taken = 1'b0;
    step();
    check_fetch("redir_run", 32'h204, word_at(32'h200), 16'd7);

    // Decode slices.
    use_ovr = 1'b1; ovr_word = 32'h0000_0003;
    step();
    check("add_opc", {26'd0, ibus_opcode}, 32'd0);
    check("add_funct", {26'd0, funct}, 32'd3);
    check("add_fields", {rs, rt, rd, imm16, 1'b0}, {5'd0, 5'd0, 5'd0, 16'h0003, 1'b0});
    ovr_word = 32'h0123_4567;
    step();
    check("dec_opc", {26'd0, ibus_opcode}, 32'd0);
    check("dec_rs", {27'd0, rs}, 32'd9);
    check("dec_rt", {27'd0, rt}, 32'd3);
    check("dec_rd", {27'd0, rd}, 32'd8);
    check("dec_imm", {16'd0, imm16}, 32'h4567);
    check("dec_funct", {26'd0, funct}, 32'h27);
    ovr_word = 32'hFFFF_FFFF;
    step();
    check("dec_opc_ones", {26'd0, ibus_opcode}, 32'h3F);
    use_ovr = 1'b0;

    // Reach PC=0x40, then pulse reset mid-cycle.
    branch_taken = 1'b1; branch_target = 32'h38;
    step();
    branch_taken = 1'b0;
    step();
    step();
    check("pre_rst_pc", iaddrbus, 32'h40);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pc", iaddrbus, 32'h0);
    check("arst_instr", ifid_instr, 32'h0);
    check("arst_pc4", ifid_pc4, 32'h0);
    check("arst_valid", {31'd0, ifid_valid}, 32'd0);
    check("arst_cnt", {16'd0, fetch_count}, 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    check("reboot_pc", iaddrbus, 32'h0);
    check("reboot_valid", {31'd0, ifid_valid}, 32'd0);
    step();
    check_fetch("rerun", 32'h4, word_at(32'h0), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
